// File: rtl/seq_detect_ctrl.sv
// Frame-level controller: serializes parallel words MSB-first and runs a
// programmable length-1..8 pattern matcher on the resulting bit stream.
module seq_detect_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [7:0]        cfg_pattern,
    input  logic [3:0]        cfg_len,
    input  logic              cfg_overlap,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              x_out,
    output logic              x_valid,
    output logic              det,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PAT_W     = 8;
    localparam int unsigned LEN_W     = 4;
    localparam int unsigned FILL_W    = 4;
    localparam int unsigned BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [PAT_W-1:0]  DEF_PATTERN = 8'b0000_1011;
    localparam logic [LEN_W-1:0]  DEF_LEN     = 4'd4;
    localparam logic [FILL_W-1:0] FILL_MAX    = 4'd8;
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [DATA_W-1:0]    r_sreg;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic                 r_last;

    logic [PAT_W-1:0]     r_pattern;
    logic [LEN_W-1:0]     r_len;
    logic                 r_overlap;

    logic [PAT_W-1:0]     r_hist;
    logic [FILL_W-1:0]    r_fill;
    logic                 r_det;
    logic [CNT_W-1:0]     r_match_cnt;
    logic                 r_frame_start;

    logic                 w_accept;
    logic                 w_shift;
    logic                 w_cfg_wr;
    logic [LEN_W-1:0]     w_len_clamped;
    logic [PAT_W-1:0]     w_mask;
    logic [PAT_W-1:0]     w_hist_next;
    logic [FILL_W-1:0]    w_fill_plus;
    logic [FILL_W-1:0]    w_fill_inc;
    logic                 w_match;

    assign w_accept = in_valid & in_ready;
    assign w_shift  = (r_state == S_SHIFT);
    assign w_cfg_wr = cfg_we & (r_state == S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_bit_cnt == '0) begin
                    w_state_next = r_last ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output decode; in_ready is held low while reset is asserted
    always_comb begin
        in_ready  = 1'b0;
        x_valid   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = ~rst;
            end
            S_SHIFT: begin
                x_valid = 1'b1;
                busy    = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
        x_out     = x_valid & r_sreg[DATA_W-1];
        det       = r_det;
        match_cnt = r_match_cnt;
    end

    // Word serializer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg    <= '0;
            r_bit_cnt <= '0;
            r_last    <= 1'b0;
        end else if (w_accept) begin
            r_sreg    <= in_data;
            r_bit_cnt <= BIT_CNT_W'(DATA_W - 1);
            r_last    <= in_last;
        end else if (w_shift) begin
            r_sreg    <= r_sreg << 1;
            r_bit_cnt <= r_bit_cnt - BIT_CNT_W'(1);
        end
    end

    // Length 0 means 1, anything above 8 means 8
    always_comb begin
        if (cfg_len == '0) begin
            w_len_clamped = LEN_W'(1);
        end else if (cfg_len > LEN_W'(PAT_W)) begin
            w_len_clamped = LEN_W'(PAT_W);
        end else begin
            w_len_clamped = cfg_len;
        end
    end

    // Detector configuration, writable only while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern <= DEF_PATTERN;
            r_len     <= DEF_LEN;
            r_overlap <= 1'b1;
        end else if (w_cfg_wr) begin
            r_pattern <= cfg_pattern;
            r_len     <= w_len_clamped;
            r_overlap <= cfg_overlap;
        end
    end

    always_comb begin
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
    end

    assign w_hist_next = {r_hist[PAT_W-2:0], r_sreg[DATA_W-1]};
    assign w_fill_plus = r_fill + FILL_W'(1);
    assign w_fill_inc  = (r_fill == FILL_MAX) ? FILL_MAX : w_fill_plus;
    assign w_match     = w_shift
                       & (w_fill_plus >= FILL_W'(r_len))
                       & (((w_hist_next ^ r_pattern) & w_mask) == '0);

    // Matcher history, fill level and per-frame match counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist        <= '0;
            r_fill        <= '0;
            r_det         <= 1'b0;
            r_match_cnt   <= '0;
            r_frame_start <= 1'b1;
        end else begin
            r_det <= w_match;
            if (w_accept && r_frame_start) begin
                r_hist        <= '0;
                r_fill        <= '0;
                r_match_cnt   <= '0;
                r_frame_start <= 1'b0;
            end else if (w_shift) begin
                r_hist <= w_hist_next;
                r_fill <= (w_match && !r_overlap) ? '0 : w_fill_inc;
                if (w_match && (r_match_cnt != CNT_MAX)) begin
                    r_match_cnt <= r_match_cnt + CNT_W'(1);
                end
            end
            if (r_state == S_DONE) begin
                r_frame_start <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl with a frame-level reference model that
// is compared against the DUT outputs every cycle.
module tb_seq_detect_ctrl;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [7:0]        cfg_pattern = '0;
    logic [3:0]        cfg_len = '0;
    logic              cfg_overlap = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic              x_out;
    logic              x_valid;
    logic              det;
    logic [CNT_W-1:0]  match_cnt;
    logic              busy;
    logic              done;

    seq_detect_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .x_out(x_out), .x_valid(x_valid), .det(det), .match_cnt(match_cnt),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp_len(input logic [3:0] l);
        if (l == 4'd0) return 1;
        if (l > 4'd8) return 8;
        return int'(l);
    endfunction

    // Reference model: phase 0 idle, 1 shifting, 2 frame done
    int         m_phase = 0;
    bit         m_bits[$];
    bit         m_last;
    bit         m_frame[$];
    int         m_guard;
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ov;
    int         m_cnt;
    bit         m_det;
    bit         m_fs;
    bit         chk_en = 1'b0;
    bit         mb;
    bit         mhit;
    bit         mdet;
    int         mn;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_bits.delete();
            m_frame.delete();
            m_guard = 0;
            m_pat   = 8'b0000_1011;
            m_len   = 4;
            m_ov    = 1'b1;
            m_cnt   = 0;
            m_det   = 1'b0;
            m_fs    = 1'b1;
            m_last  = 1'b0;
        end else begin
            mdet = 1'b0;
            case (m_phase)
                0: begin
                    if (cfg_we) begin
                        m_pat = cfg_pattern;
                        m_len = clamp_len(cfg_len);
                        m_ov  = cfg_overlap;
                    end
                    if (in_valid) begin
                        if (m_fs) begin
                            m_cnt = 0;
                            m_frame.delete();
                            m_guard = 0;
                            m_fs = 1'b0;
                        end
                        m_bits.delete();
                        for (int i = DATA_W - 1; i >= 0; i--) m_bits.push_back(in_data[i]);
                        m_last  = in_last;
                        m_phase = 1;
                    end
                end
                1: begin
                    mb = m_bits.pop_front();
                    m_frame.push_back(mb);
                    mn = m_frame.size();
                    if (mn - m_guard >= m_len) begin
                        mhit = 1'b1;
                        for (int j = 0; j < m_len; j++) begin
                            if (m_frame[mn-1-j] != m_pat[j]) mhit = 1'b0;
                        end
                        if (mhit) begin
                            mdet = 1'b1;
                            if (m_cnt < 255) m_cnt++;
                            if (!m_ov) m_guard = mn;
                        end
                    end
                    if (m_bits.size() == 0) m_phase = m_last ? 2 : 0;
                end
                default: begin
                    m_phase = 0;
                    m_fs = 1'b1;
                end
            endcase
            m_det = mdet;
        end
    end

    // Per-test observation of the DUT
    int         det_seen;
    int         done_cnt;
    logic [7:0] stream;

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 32'(in_ready), 32'(m_phase == 0 && !rst));
            check("x_valid", 32'(x_valid), 32'(m_phase == 1));
            check("x_out", 32'(x_out), (m_phase == 1) ? 32'(m_bits[0]) : 32'd0);
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("done", 32'(done), 32'(m_phase == 2));
            check("det", 32'(det), 32'(m_det));
            check("match_cnt", 32'(match_cnt), 32'(m_cnt));
            if (x_valid) stream = {stream[6:0], x_out};
            if (det) det_seen++;
            if (done) done_cnt = int'(match_cnt);
        end
    end

    task automatic reset_stats();
        det_seen = 0;
        done_cnt = -1;
        stream   = '0;
    endtask

    task automatic send_word(input logic [7:0] d, input logic l);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("handshake", 32'(ok), 32'd1);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic cfg_write(input logic [7:0] p, input logic [3:0] l, input logic ov);
        cfg_we      = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ov;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_stats();
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_det", 32'(det), 32'd0);
        check("rst_match_cnt", 32'(match_cnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_x_valid", 32'(x_valid), 32'd0);
        @(posedge clk);
        #1;

        // Default config, overlapping 1011 in 1011_0110
        reset_stats();
        send_word(8'hB6, 1'b1);
        wait_done();
        check("t2_stream", 32'(stream), 32'hB6);
        check("t2_det_count", 32'(det_seen), 32'd2);
        check("t2_final_cnt", 32'(done_cnt), 32'd2);

        // Non-overlapping
        cfg_write(8'h0B, 4'd4, 1'b0);
        reset_stats();
        send_word(8'hB6, 1'b1);
        wait_done();
        check("t3_det_count", 32'(det_seen), 32'd1);
        check("t3_final_cnt", 32'(done_cnt), 32'd1);

        // Match spanning a word boundary with a producer gap
        cfg_write(8'h0B, 4'd4, 1'b1);
        reset_stats();
        send_word(8'h02, 1'b0);
        repeat (DATA_W + 3) @(posedge clk);
        #1;
        send_word(8'hC0, 1'b1);
        wait_done();
        check("t4_det_count", 32'(det_seen), 32'd1);
        check("t4_final_cnt", 32'(done_cnt), 32'd1);

        // len 0 -> 1, config write while shifting is ignored
        cfg_write(8'h01, 4'd0, 1'b1);
        reset_stats();
        send_word(8'hA5, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        cfg_write(8'h00, 4'd1, 1'b1);
        wait_done();
        check("t5_det_count", 32'(det_seen), 32'd4);
        check("t5_final_cnt", 32'(done_cnt), 32'd4);

        // Counter saturation over 256 matches
        cfg_write(8'h01, 4'd1, 1'b1);
        reset_stats();
        for (int w = 0; w < 32; w++) send_word(8'hFF, 1'(w == 31));
        wait_done();
        check("t6_sat_cnt", 32'(done_cnt), 32'd255);

        // Reset on the 4th bit of a new word
        reset_stats();
        send_word(8'hFF, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_in_ready", 32'(in_ready), 32'd1);
        check("t6_rst_x_valid", 32'(x_valid), 32'd0);
        check("t6_rst_match_cnt", 32'(match_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset_stats();
        send_word(8'hB6, 1'b1);
        wait_done();
        check("t6_default_cfg_cnt", 32'(done_cnt), 32'd2);
        check("t6_default_cfg_det", 32'(det_seen), 32'd2);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Frame-level controller that sequences the serial sequence-detector datapath. It accepts parallel words over a valid/ready handshake and serializes them MSB-first onto a 1-bit stream (x_out/x_valid). It runs a programmable pattern matcher (length 1..8, overlapping or non-overlapping) on that stream, counts matches per frame and signals frame completion. It sits between a word-oriented producer and the bit-serial detector domain, and owns detector configuration.

Parameters:
DATA_W, 8, width of input word, bits serialized per word
CNT_W, 8, width of saturating per-frame match counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cfg_we  in  1  configuration write strobe, honoured only in IDLE
cfg_pattern  in  8  pattern; bit[len-1] is the first bit expected, bit0 the last
cfg_len  in  4  pattern length; 0 treated as 1, values >8 clamped to 8
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
in_valid  in  1  producer word valid
in_data  in  DATA_W  word to serialize, MSB first
in_last  in  1  word is last of frame, sampled with in_data
in_ready  out  1  controller can accept a word
x_out  out  1  current serial bit
x_valid  out  1  x_out is a live stream bit
det  out  1  one-cycle pulse per detected pattern
match_cnt  out  CNT_W  matches in current/last frame, saturating
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse at end of frame

Behaviour:
- This block uses one clock; reset is synchronous and active-high.
- Reset values: in_ready=0 during the reset cycle, then 1; x_out=0, x_valid=0, det=0, match_cnt=0, busy=0, done=0.
- Configuration reset defaults: pattern=8'b0000_1011, len=4, overlap=1. Reset also clears history, fill count and the frame-start flag.
- FSM: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. A handshake (in_valid & in_ready) loads in_data into the shift register, latches in_last, sets bit_cnt=DATA_W-1 and moves to SHIFT.
- Frame start: if the accepted word is the first of a frame (after reset or after DONE), match_cnt, history and fill count are cleared on the same edge.
- in_data and in_last are sampled only on the handshake. in_valid may stay high across any number of cycles.
- SHIFT: each cycle x_valid=1 and x_out=sreg[MSB]. Shift left at the edge and decrement bit_cnt.
  - When bit_cnt==0: go to DONE if the latched last flag is set, else go to IDLE.
  - Throughput is DATA_W+1 cycles per word (one IDLE bubble). x_valid=0 in the bubble, and history does not advance.
- DONE: one cycle; done=1, in_ready=0, then return to IDLE.
- Matcher: history is an 8-bit shift register, (hist<<1)|x_out, updated on every x_valid cycle. fill saturates at 8.
  - Match condition: (fill+1 >= len) and the low len bits of the next history equal the low len bits of the pattern.
  - det is registered: it is high in the cycle after the completing bit. match_cnt increments on the same edge and holds at 2^CNT_W-1.
- Non-overlapping mode: a match resets fill to 0, so matched bits cannot be reused. Overlapping mode: fill is unaffected by a match.
- Matching spans word boundaries within a frame; history is cleared only at frame start.
- Last-bit timing: det for the final bit of a frame coincides with done, and match_cnt is final in that cycle. match_cnt holds until the next frame starts.
- cfg_we outside IDLE is ignored. A config write in IDLE between words of a frame takes effect for the next bit; history is kept.
- If in_valid and cfg_we occur in the same IDLE cycle, both are applied; the new config governs the word's bits.
- Reset mid-frame: the next cycle is IDLE with reset values and default config. The partial word is discarded.

Test Plan:
1. Reset -> cycle after rst release: in_ready=1, busy=0, det=0, match_cnt=0, done=0, x_valid=0.
2. Default config (1011, len 4, overlap=1), one word 8'b1011_0110 with last=1 -> x_out sequence 1,0,1,1,0,1,1,0; det pulses after bit 3 and after bit 6; done=1 with match_cnt=2.
3. Same word with cfg_overlap=0 written in IDLE -> single det after bit 3; match_cnt=1 at done.
4. Cross-word frame, default config, words 8'h02 then 8'hC0 (last) with the producer withholding in_valid 3 cycles between them -> exactly one det, on bit 1 of the second word (stream …1,0 | 1,1); match_cnt=1.
5. cfg_len=0, cfg_pattern=8'h01, word 8'hA5 last -> 4 det pulses. A cfg_we pulse mid-SHIFT with pattern 8'h00 is ignored; match_cnt=4.
6. Saturation and reset: len 1, pattern 1, 32 words of 8'hFF (last on the 32nd) -> match_cnt sticks at 255. Then rst asserted on the 4th bit of a new word -> next cycle in_ready=1, x_valid=0, match_cnt=0, config back to defaults.
